// File: rtl/freq_meas_ctrl.sv
// Gated frequency counter sequencer: clear, gate, settle, evaluate with auto-range retry, publish.
// Publishes G+S+2 cycles after CLEAR (2*(G+S+2) when retried); there is no backpressure, and valid is a one-cycle strobe.
module freq_meas_ctrl #(
    parameter int CW            = 21,
    parameter int GATE_CYCLES   = 50000000,
    parameter int SETTLE_CYCLES = 4,
    parameter int UP_TH         = 9999,
    parameter int DN_TH         = 900
) (
    input  logic          sysclk,
    input  logic          rst,
    input  logic          run,
    input  logic          auto_rng,
    input  logic          range_in,
    input  logic [CW-1:0] cnt_val,
    output logic          cnt_clr,
    output logic          cnt_en,
    output logic          range,
    output logic [13:0]   result,
    output logic          overflow,
    output logic          valid,
    output logic          busy
);

    localparam int GW = $clog2(GATE_CYCLES + 1);
    localparam int SW = $clog2(SETTLE_CYCLES + 1);

    localparam logic [GW-1:0] GATE_LAST   = GW'(GATE_CYCLES - 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] UP_C        = CW'(UP_TH);
    localparam logic [CW-1:0] DN_C        = CW'(DN_TH);
    localparam logic [13:0]   UP_RES      = 14'(UP_TH);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CLEAR   = 3'd1,
        S_GATE    = 3'd2,
        S_SETTLE  = 3'd3,
        S_EVAL    = 3'd4,
        S_PUBLISH = 3'd5
    } state_t;

    state_t        r_state;
    state_t        w_next;

    logic [GW-1:0] r_gate_cnt;
    logic [SW-1:0] r_settle_cnt;
    logic          r_auto;
    logic          r_retry;
    logic          r_range;
    logic [13:0]   r_result;
    logic          r_overflow;

    logic          w_gate_done;
    logic          w_settle_done;
    logic          w_over;
    logic          w_retry_take;

    assign w_gate_done   = (r_gate_cnt == GATE_LAST);
    assign w_settle_done = (r_settle_cnt == SETTLE_LAST);
    assign w_over        = (cnt_val > UP_C);

    // A single re-measure is allowed; once r_retry is set the next EVAL publishes whatever it sees.
    assign w_retry_take = r_auto && !r_retry &&
                          ((!r_range && w_over) || (r_range && (cnt_val < DN_C)));

    always_ff @(posedge sysclk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (run) w_next = S_CLEAR;
            S_CLEAR:   w_next = S_GATE;
            S_GATE:    if (w_gate_done) w_next = S_SETTLE;
            S_SETTLE:  if (w_settle_done) w_next = S_EVAL;
            S_EVAL:    w_next = w_retry_take ? S_CLEAR : S_PUBLISH;
            S_PUBLISH: w_next = run ? S_CLEAR : S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge sysclk) begin
        if (rst) begin
            r_gate_cnt   <= '0;
            r_settle_cnt <= '0;
            r_auto       <= 1'b0;
            r_retry      <= 1'b0;
            r_range      <= 1'b0;
            r_result     <= '0;
            r_overflow   <= 1'b0;
        end else begin
            if (r_state == S_GATE && !w_gate_done) begin
                r_gate_cnt <= r_gate_cnt + GW'(1);
            end else begin
                r_gate_cnt <= '0;
            end

            if (r_state == S_SETTLE && !w_settle_done) begin
                r_settle_cnt <= r_settle_cnt + SW'(1);
            end else begin
                r_settle_cnt <= '0;
            end

            case (r_state)
                S_CLEAR: begin
                    // Mode and manual range are frozen for the whole measurement, including its retry.
                    if (!r_retry) begin
                        r_auto <= auto_rng;
                        if (!auto_rng) begin
                            r_range <= range_in;
                        end
                    end
                end
                S_EVAL: begin
                    if (w_retry_take) begin
                        r_range <= ~r_range;
                        r_retry <= 1'b1;
                    end else begin
                        r_result   <= w_over ? UP_RES : 14'(cnt_val);
                        r_overflow <= w_over;
                    end
                end
                S_PUBLISH: begin
                    r_retry <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    assign cnt_clr  = (r_state == S_CLEAR);
    assign cnt_en   = (r_state == S_GATE);
    assign valid    = (r_state == S_PUBLISH);
    assign busy     = (r_state != S_IDLE);
    assign range    = r_range;
    assign result   = r_result;
    assign overflow = r_overflow;

endmodule
